// File: rtl/div_if.sv
// Execute-stage <-> divider handshake bundle: operands and start/annul in, {remainder, quotient} and ready out.
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Restoring divider, one quotient bit per edge: result 33 edges after start is sampled (1 edge for divide-by-zero).
// Result and ready are held while start_i stays high; dropping start_i releases them on the next edge.
module div #(
    parameter int DATA_W = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam int CW = $clog2(DATA_W) + 1;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BYZERO = 2'd1;
    localparam logic [1:0] ON     = 2'd2;
    localparam logic [1:0] END    = 2'd3;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   r;
    logic [DATA_W-1:0]   q;
    logic [DATA_W-1:0]   d;
    logic                neg_q;
    logic                neg_r;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic                ge;
    logic [DATA_W-1:0]   r_next;

    assign a_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign b_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign a_abs = a_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    assign b_abs = b_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

    // The partial remainder plus the incoming dividend bit needs one extra bit before the compare.
    assign shifted = {r, q[DATA_W-1]};
    assign diff    = shifted - {1'b0, d};
    assign ge      = ~diff[DATA_W];
    assign r_next  = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FREE;
            cnt          <= '0;
            r            <= '0;
            q            <= '0;
            d            <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= '0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state <= ON;
                            d     <= b_abs;
                            q     <= a_abs;
                            r     <= '0;
                            cnt   <= '0;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end
                end
                BYZERO: begin
                    if (bus.annul_i) begin
                        state <= FREE;
                    end else begin
                        state        <= END;
                        bus.ready_o  <= 1'b1;
                        bus.result_o <= '0;
                    end
                end
                ON: begin
                    if (bus.annul_i) begin
                        state        <= FREE;
                        cnt          <= '0;
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= '0;
                    end else if (cnt != CW'(DATA_W)) begin
                        r   <= r_next;
                        q   <= {q[DATA_W-2:0], ge};
                        cnt <= cnt + 1'b1;
                    end else begin
                        state        <= END;
                        bus.ready_o  <= 1'b1;
                        bus.result_o <= {neg_r ? (~r + 1'b1) : r,
                                         neg_q ? (~q + 1'b1) : q};
                    end
                end
                END: begin
                    if (!bus.start_i) begin
                        state        <= FREE;
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= '0;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Directed bench for the restoring divider: vector table plus annul and reset sequences.
module tb_div;
    logic clk;
    logic rst;

    div_if #(.DATA_W(32)) dif ();

    div #(.DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
        int          hold;
    } vec_t;

    vec_t vecs[9];
    int   errors;
    int   checks;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h required 0x%h", nm, act, exp);
        end
    endtask

    // Issues one request, measures ready latency, checks the result, optionally holds, then releases.
    task automatic run_div(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int exp_lat, input int hold);
        int got;
        logic stable;
        @(negedge clk);
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        @(posedge clk);
        got = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (dif.ready_o) begin
                got = k;
                break;
            end
        end
        chk({nm, "_latency"}, 64'(got), 64'(exp_lat));
        chk({nm, "_result"}, dif.result_o, exp_res);
        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                if (!dif.ready_o || dif.result_o !== exp_res) stable = 1'b0;
            end
            chk({nm, "_hold"}, 64'(stable), 64'd1);
        end
        @(negedge clk);
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_release"}, {31'd0, dif.ready_o, dif.result_o[31:0]}, 64'd0);
        chk({nm, "_release_hi"}, {32'd0, dif.result_o[63:32]}, 64'd0);
    endtask

    initial begin
        int seen;
        errors = 0;
        checks = 0;

        vecs[0] = '{"u100_7",    1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 0};
        vecs[1] = '{"s_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 0};
        vecs[2] = '{"s7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 0};
        vecs[3] = '{"u_fff9_2",  1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33, 0};
        vecs[4] = '{"s5_0",      1'b1, 32'd5,          32'd0,          64'h0,                 1, 10};
        vecs[5] = '{"u5_0",      1'b0, 32'd5,          32'd0,          64'h0,                 1, 10};
        vecs[6] = '{"s_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 0};
        vecs[7] = '{"u_ovf",     1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33, 3};
        vecs[8] = '{"s_m100_7",  1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 33, 0};

        rst              = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {31'd0, dif.ready_o, dif.result_o[31:0]}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++)
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].exp_res, vecs[i].exp_lat, vecs[i].hold);

        // Annul at E10 of 1000/3, start withdrawn at the same time.
        @(negedge clk);
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd1000;
        dif.opdata2_i    = 32'd3;
        dif.start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        dif.annul_i = 1'b1;
        dif.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dif.annul_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (dif.ready_o) seen++;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 0);

        // Asynchronous reset mid-divide, between edges.
        @(negedge clk);
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd1000;
        dif.opdata2_i    = 32'd3;
        dif.start_i      = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_mid_op", {31'd0, dif.ready_o, dif.result_o[31:0]}, 64'd0);
        dif.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div("after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

        // Asynchronous reset while a result is being held.
        @(negedge clk);
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd7;
        dif.start_i      = 1'b1;
        seen = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (dif.ready_o) begin
                seen = 1;
                break;
            end
        end
        chk("end_ready_before_rst", 64'(seen), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_in_end", {31'd0, dif.ready_o, dif.result_o[31:0]}, 64'd0);
        chk("rst_in_end_hi", {32'd0, dif.result_o[63:32]}, 64'd0);
        dif.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div("final_u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit divider used as the responder to the execute stage for DIV/DIVU.
- The execute stage issues operands with start_i and holds them; this block runs a restoring division, one quotient bit per cycle.
- It returns {remainder, quotient} with ready_o, which the execute stage routes to HI/LO.
- Also responds to annul_i so a flushed divide can be abandoned.

Parameters:
- DATA_W, 32, operand width. Result width is 2*DATA_W; iteration count is DATA_W. Only 32 is required to be verified.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  input  DATA_W  dividend; sampled when start accepted.
- opdata2_i  input  DATA_W  divisor; sampled when start accepted.
- start_i  input  1  request; held high by the execute stage until it sees ready_o.
- annul_i  input  1  abandon the current/pending divide.
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  output  1  result valid; registered.

Behaviour:
- Reset (rst=0, async): state=FREE, cnt=0, result_o=0, ready_o=0, internal regs 0. Takes effect immediately, mid-operation included.
- States: FREE, BYZERO, ON, END. All transitions occur on the clk rising edge.
- FREE:
  - start_i=1 and annul_i=0, divisor==0 -> BYZERO.
  - start_i=1 and annul_i=0, divisor!=0 -> ON.
    - Latch D=|divisor| and Q=|dividend|; absolute value is taken only if signed_div_i=1 and the MSB is 1.
    - Latch the sign flags; R=0, cnt=0.
  - Otherwise stay; ready_o=0, result_o=0.
- BYZERO: next edge -> END with result_o=0, ready_o=1. If annul_i=1 -> FREE instead.
- ON:
  - annul_i=1 -> FREE, cnt=0, ready_o=0, result_o=0 (no result produced).
  - Else, while cnt<32, one restoring step per edge:
    - {R,Q} <<= 1.
    - If R >= D (33-bit compare/subtract): R -= D, Q[0] = 1.
    - cnt++.
  - cnt==32 edge: apply sign fix and -> END.
    - Quotient negated if signed and the operand signs differ.
    - Remainder negated if signed and the dividend is negative.
    - result_o={R,Q}, ready_o=1.
  - start_i going low in ON is ignored.
- END: hold result_o and ready_o stable while start_i=1. annul_i is ignored in END. start_i=0 -> FREE next edge, ready_o=0, result_o=0.
- Latency, from the edge that samples start_i=1 in FREE (E0):
  - Normal divide: 32 step edges (E1..E32), ready_o and result_o valid after E33.
  - Divide by zero: ready_o valid after E1.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
- Back-to-back: a new request needs at least one FREE cycle, i.e. start_i low for one edge after ready_o.
- cnt is 6 bits and never wraps; it is cleared on every entry to ON.

Test Plan:
- Unsigned 100/7, start held:
  - ready_o=0 through E32; ready_o=1 after E33.
  - result_o=0x00000002_0000000E.
  - Drop start -> ready_o=0, result_o=0 next edge.
- Signed -7/2 -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD. Unsigned 0xFFFFFFF9/2 -> 0x00000001_7FFFFFFC.
- Divide by zero, 5/0, signed and unsigned: ready_o=1 after E1, result_o=0. Holding start for 10 cycles keeps ready_o=1 and the result stable.
- Annul and restart:
  - Pulse annul_i at E10 of a 1000/3 divide -> state FREE; ready_o never asserts.
  - Then unsigned 0xFFFFFFFF/1 -> result_o=0x00000000_FFFFFFFF after 33 edges.
- Signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000. Unsigned same operands -> 0x80000000_00000000.
- Reset during operation:
  - rst=0 asynchronously at E15, between clock edges: ready_o=0 and result_o=0 immediately.
  - After release, start 9/3 -> result_o=0x00000000_00000003 after E33.
